// File: rtl/chord_sine_scheduler_if.sv
// Sample-request, shared sine ROM and chord sample signals of chord_sine_scheduler.
// The master side is the codec/control logic together with the ROM; the slave side is the scheduler.
interface chord_sine_scheduler_if #(
    parameter int NUM_VOICES = 3,
    parameter int STEP_W     = 20,
    parameter int ROM_AW     = 10,
    parameter int SAMPLE_W   = 16
);
    logic                           generate_next;
    logic [NUM_VOICES*STEP_W-1:0]   step_sizes;
    logic [NUM_VOICES-1:0]          voice_enable;
    logic [ROM_AW-1:0]              rom_addr;
    logic [SAMPLE_W-1:0]            rom_data;
    logic [SAMPLE_W-1:0]            sample;
    logic                           sample_ready;
    logic                           busy;
    logic                           overrun;

    modport master (
        output generate_next, step_sizes, voice_enable, rom_data,
        input  rom_addr, sample, sample_ready, busy, overrun
    );

    modport slave (
        input  generate_next, step_sizes, voice_enable, rom_data,
        output rom_addr, sample, sample_ready, busy, overrun
    );
endinterface

// File: rtl/chord_sine_scheduler.sv
// Shares one registered sine ROM among NUM_VOICES phase accumulators and sums their
// outputs into one saturated chord sample per generate_next request.
module chord_sine_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int STEP_W     = 20,
    parameter int PHASE_W    = 22,
    parameter int ROM_AW     = 10,
    parameter int SAMPLE_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    chord_sine_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int ACC_W    = SAMPLE_W + 3;
    localparam int VIDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ADDR_LSB = 10;
    localparam logic [VIDX_W-1:0] LAST_VOICE = VIDX_W'(NUM_VOICES - 1);

    state_t                       state_q;
    logic [PHASE_W-1:0]           phase_q [NUM_VOICES];
    logic [NUM_VOICES*STEP_W-1:0] step_q;
    logic [NUM_VOICES-1:0]        enable_q;
    logic [VIDX_W-1:0]            voice_q;
    logic signed [ACC_W-1:0]      acc_q;
    logic [ROM_AW-1:0]            rom_addr_q;
    logic [SAMPLE_W-1:0]          sample_q;
    logic                         sample_ready_q;
    logic                         busy_q;
    logic                         overrun_q;

    logic signed [ACC_W-1:0]      acc_d;
    logic [PHASE_W-1:0]           phase_d;
    logic [SAMPLE_W-1:0]          sample_d;
    logic [STEP_W-1:0]            step_cur;
    logic [ACC_W-SAMPLE_W:0]      acc_top;
    logic [VIDX_W-1:0]            voice_nxt;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        step_cur  = step_q[voice_q*STEP_W +: STEP_W];
        phase_d   = phase_q[voice_q] + {{(PHASE_W-STEP_W){1'b0}}, step_cur};
        acc_d     = acc_q;
        if (enable_q[voice_q]) begin
            acc_d = acc_q + {{(ACC_W-SAMPLE_W){bus.rom_data[SAMPLE_W-1]}}, bus.rom_data};
        end
        // The upper bits all match the sample sign bit only when the sum fits in SAMPLE_W bits.
        acc_top   = acc_d[ACC_W-1:SAMPLE_W-1];
        sample_d  = acc_d[SAMPLE_W-1:0];
        if (!((&acc_top) || !(|acc_top))) begin
            sample_d = acc_d[ACC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
        voice_nxt = voice_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            // NOTE: the phase array is a handful of registers, not a RAM, so it is reset like any other state.
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= '0;
            end
            step_q         <= '0;
            enable_q       <= '0;
            voice_q        <= '0;
            acc_q          <= '0;
            rom_addr_q     <= '0;
            sample_q       <= '0;
            sample_ready_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            sample_ready_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.generate_next) begin
                        step_q     <= bus.step_sizes;
                        enable_q   <= bus.voice_enable;
                        voice_q    <= '0;
                        acc_q      <= '0;
                        rom_addr_q <= phase_q[0][ADDR_LSB +: ROM_AW];
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end else begin
                        rom_addr_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                ISSUE: begin
                    if (bus.generate_next) overrun_q <= 1'b1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.generate_next) overrun_q <= 1'b1;
                    acc_q            <= acc_d;
                    phase_q[voice_q] <= enable_q[voice_q] ? phase_d : '0;
                    if (voice_q == LAST_VOICE) begin
                        sample_q       <= sample_d;
                        sample_ready_q <= 1'b1;
                        rom_addr_q     <= '0;
                        state_q        <= DONE;
                    end else begin
                        // The next voice's phase is not touched this edge, so its current value is the address.
                        voice_q    <= voice_nxt;
                        rom_addr_q <= phase_q[voice_nxt][ADDR_LSB +: ROM_AW];
                        state_q    <= ISSUE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rom_addr     = rom_addr_q;
    assign bus.sample       = sample_q;
    assign bus.sample_ready = sample_ready_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: doc/chord_sine_scheduler.md
Name: chord_sine_scheduler

Overview:
Time-multiplexes one registered sine ROM (1024 x 16, one-cycle read latency) among NUM_VOICES phase-accumulator voices to produce a chord sample. Each generate_next request walks the voices in order, accumulates their ROM outputs, saturates the sum to 16 bits and presents one sample. It sits between the note/chord control logic and the codec sample interface, in place of one phase reader per voice.

Parameters:
NUM_VOICES, 3, number of voices sharing the ROM (1..8)
STEP_W, 20, per-voice step size width
PHASE_W, 22, phase accumulator width
ROM_AW, 10, ROM address width; address = phase[19:10]
SAMPLE_W, 16, signed sample width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (asserted at 0)
generate_next  in  1  one-cycle sample request from codec side
step_sizes  in  NUM_VOICES*STEP_W  voice v step at [v*STEP_W +: STEP_W]
voice_enable  in  NUM_VOICES  per-voice enable
rom_addr  out  ROM_AW  address to shared sine ROM
rom_data  in  SAMPLE_W  signed ROM output, valid one cycle after address
sample  out  SAMPLE_W  signed saturated chord sample
sample_ready  out  1  one-cycle pulse, sample updated
busy  out  1  high from request acceptance until the DONE cycle inclusive
overrun  out  1  sticky, set when a request is dropped

Behaviour:
- Reset (reset=0, async): state IDLE; all phases, voice index, accumulator, sample, rom_addr, sample_ready, busy, overrun = 0.
- FSM: IDLE, ISSUE, WAIT, DONE.
- IDLE: rom_addr=0. generate_next=1 at edge -> latch step_sizes and voice_enable, v=0, acc=0 -> ISSUE.
- ISSUE: rom_addr = phase[v][19:10] -> WAIT.
- WAIT: rom_addr held. At edge: if enable[v], acc += sign-extended rom_data and phase[v] <= (phase[v] + zero-extended step[v]) mod 2^22; if not enabled, phase[v] <= 0 and acc unchanged. If v = NUM_VOICES-1 -> DONE, else v+1 -> ISSUE.
- acc width SAMPLE_W+3; no intermediate overflow for 8 voices.
- Entering DONE: sample <= sat(acc) (clamp to 16'h7FFF / 16'h8000); sample_ready=1 for the DONE cycle only; sample holds until the next DONE.
- DONE: generate_next=1 -> accepted exactly as in IDLE (back-to-back frames), else -> IDLE.
- Latency: request sampled at edge E0 -> sample_ready high in cycle after E(2*NUM_VOICES) (6 cycles for default).
- generate_next=1 in ISSUE/WAIT: ignored, overrun <= 1; cleared only by reset.
- Step/enable changes mid-frame take effect next frame (latched values used).
- All-disabled frame: sample = 0, sample_ready still pulses.
- Reset mid-frame: immediate return to reset values; no sample_ready after release.

Test Plan:
- Reset: reset=0 with random inputs -> all outputs 0; after release and 20 idle cycles, still 0 and rom_addr=0.
- Single voice: enable=3'b001, step0=20'h00400, bench ROM returns addr*4 -> three requests give voice-0 rom_addr 0,1,2; sample 0,4,8; sample_ready exactly 6 cycles after each request; voices 1–2 phase stays 0.
- Saturation: enable=3'b111, ROM constant 16'h7000 -> sample 16'h7FFF; ROM 16'h9000 -> 16'h8000; ROM 16'h0100 -> 16'h0300.
- Wrap/slice: step0=20'h80400 -> voice-0 rom_addr at request 2 = 10'h201. step0=20'hFFFFF, 5 requests -> phase0 = 22'h0FFFFB, 6th rom_addr = 10'h3FF.
- Handshake: generate_next pulsed 2 cycles after acceptance -> ignored, overrun=1, one sample_ready. generate_next pulsed in the DONE cycle -> accepted, next sample_ready 6 cycles later, busy stays high.
- Reset mid-frame: assert reset=0 during the cycle after E3 -> outputs 0 immediately; no pulse after release; next request restarts from phase 0.
